// File: rtl/apb_master_bridge.sv
// APB requester bridging a valid/ready command port onto two 8-bit slaves.
// Slave choice comes from address bit 8; wait states are bounded by a timeout.
module apb_master_bridge #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic       PCLK,
  input  logic       PRESET,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [8:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_error,
  output logic       PSEL1,
  output logic       PSEL2,
  output logic       PENABLE,
  output logic       PWRITE,
  output logic [7:0] PADDR,
  output logic [7:0] PWDATA,
  input  logic       PREADY1,
  input  logic       PREADY2,
  input  logic [7:0] PRDATA1,
  input  logic [7:0] PRDATA2
);

  localparam int CW =
    (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TO   = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CMAX = '1;
  localparam logic [CW-1:0] ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t        state;
  logic          sel2;
  logic [CW-1:0] wcnt;
  logic          rdy_sel;
  logic [7:0]    rdata_sel;
  logic [CW-1:0] wcnt_inc;
  logic          tmo_hit;

  // The slave that was not addressed never influences the transfer.
  assign rdy_sel   = sel2 ? PREADY2 : PREADY1;
  assign rdata_sel = sel2 ? PRDATA2 : PRDATA1;

  // Saturating so a disabled timeout can wait forever without wrapping.
  assign wcnt_inc = (wcnt == CMAX) ? wcnt : wcnt + ONE;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (wcnt_inc == TO);

  // Transfer FSM; every bus and response output is registered here.
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state     <= IDLE;
      sel2      <= 1'b0;
      wcnt      <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 8'h00;
      rsp_error <= 1'b0;
      PSEL1     <= 1'b0;
      PSEL2     <= 1'b0;
      PENABLE   <= 1'b0;
      PWRITE    <= 1'b0;
      PADDR     <= 8'h00;
      PWDATA    <= 8'h00;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_ready && req_valid) begin
            state     <= SETUP;
            req_ready <= 1'b0;
            sel2      <= req_addr[8];
            PSEL1     <= ~req_addr[8];
            PSEL2     <= req_addr[8];
            PADDR     <= req_addr[7:0];
            PWRITE    <= req_write;
            PWDATA    <= req_wdata;
            wcnt      <= '0;
          end else begin
            req_ready <= 1'b1;
          end
        end
        SETUP: begin
          state   <= ACCESS;
          PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (rdy_sel) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            PSEL1     <= 1'b0;
            PSEL2     <= 1'b0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_error <= 1'b0;
            rsp_rdata <= PWRITE ? 8'h00 : rdata_sel;
          end else begin
            wcnt <= wcnt_inc;
            if (tmo_hit) begin
              state     <= IDLE;
              req_ready <= 1'b1;
              PSEL1     <= 1'b0;
              PSEL2     <= 1'b0;
              PENABLE   <= 1'b0;
              rsp_valid <= 1'b1;
              rsp_error <= 1'b1;
              rsp_rdata <= 8'h00;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: two memory slaves with programmable wait
// states, a transaction-level model checked every cycle, directed tests.
module tb_apb_master_bridge;

  localparam int TO = 4;

  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [8:0] req_addr = 9'h000;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       PSEL1, PSEL2, PENABLE, PWRITE;
  logic [7:0] PADDR, PWDATA;
  logic       PREADY1, PREADY2;
  logic [7:0] PRDATA1, PRDATA2;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE),
    .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PREADY1(PREADY1), .PREADY2(PREADY2),
    .PRDATA1(PRDATA1), .PRDATA2(PRDATA2)
  );

  always #5 PCLK = ~PCLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp,
               $time);
    end
  endtask

  function automatic logic [7:0] pat1(input int i);
    return (i == 16) ? 8'h77 : 8'(i) ^ 8'h5A;
  endfunction

  function automatic logic [7:0] pat2(input int i);
    return 8'(i) ^ 8'hC3;
  endfunction

  // Slaves: memory with a per-transfer count of wait cycles
  logic [7:0] mem1 [256];
  logic [7:0] mem2 [256];
  int acc1 = 0, acc2 = 0;
  int wait1 = 0, wait2 = 0;

  assign PREADY1 = PSEL1 && PENABLE && (acc1 >= wait1);
  assign PREADY2 = PSEL2 && PENABLE && (acc2 >= wait2);
  assign PRDATA1 = mem1[PADDR];
  assign PRDATA2 = mem2[PADDR];

  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (PRESET) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= pat1(i);
        mem2[i] <= pat2(i);
      end
      acc1 <= 0;
      acc2 <= 0;
    end else begin
      if (PSEL1 && PENABLE && !PREADY1) acc1 <= acc1 + 1;
      else if (!(PSEL1 && PENABLE)) acc1 <= 0;
      if (PSEL2 && PENABLE && !PREADY2) acc2 <= acc2 + 1;
      else if (!(PSEL2 && PENABLE)) acc2 <= 0;
      if (PSEL1 && PENABLE && PREADY1 && PWRITE) mem1[PADDR] <= PWDATA;
      if (PSEL2 && PENABLE && PREADY2 && PWRITE) mem2[PADDR] <= PWDATA;
    end
  end

  // Model: a transfer is a schedule -- setup cycle, then len access
  // cycles, then the response; len and error follow from the wait count.
  logic [7:0] ref1 [256];
  logic [7:0] ref2 [256];
  bit         m_busy = 1'b0;
  int         m_t = 0, m_len = 0;
  bit         m_err = 1'b0, m_sel2 = 1'b0, m_wr = 1'b0;
  logic [7:0] m_addr = 8'h00;
  logic       e_ready = 1'b0, e_rsp_valid = 1'b0, e_err = 1'b0;
  logic [7:0] e_rdata = 8'h00;
  logic       e_pwrite = 1'b0;
  logic [7:0] e_paddr = 8'h00, e_pwdata = 8'h00;

  always @(posedge PCLK) begin
    int w;
    if (PRESET) begin
      m_busy = 1'b0; m_t = 0; m_sel2 = 1'b0;
      e_ready = 1'b0; e_rsp_valid = 1'b0; e_err = 1'b0;
      e_rdata = 8'h00; e_pwrite = 1'b0;
      e_paddr = 8'h00; e_pwdata = 8'h00;
      for (int i = 0; i < 256; i++) begin
        ref1[i] = pat1(i);
        ref2[i] = pat2(i);
      end
    end else begin
      e_rsp_valid = 1'b0;
      if (!m_busy) begin
        if (e_ready && req_valid) begin
          m_busy = 1'b1; m_t = 1; e_ready = 1'b0;
          m_sel2 = req_addr[8]; m_wr = req_write;
          m_addr = req_addr[7:0];
          e_paddr = req_addr[7:0]; e_pwdata = req_wdata;
          e_pwrite = req_write;
          w = req_addr[8] ? wait2 : wait1;
          if (TO != 0 && w >= TO) begin m_len = TO; m_err = 1'b1; end
          else begin m_len = w + 1; m_err = 1'b0; end
        end else begin
          e_ready = 1'b1;
        end
      end else if (m_t == 1 + m_len) begin
        m_busy = 1'b0; e_ready = 1'b1; e_rsp_valid = 1'b1;
        e_err = m_err;
        if (m_err || m_wr) e_rdata = 8'h00;
        else e_rdata = m_sel2 ? ref2[m_addr] : ref1[m_addr];
        if (m_wr && !m_err) begin
          if (m_sel2) ref2[m_addr] = e_pwdata;
          else ref1[m_addr] = e_pwdata;
        end
      end else begin
        m_t++;
      end
    end
  end

  // Compare process, plus cycle counters used by directed tests
  int sel_cyc = 0, pen_cyc = 0, rsp_cnt = 0;

  always @(negedge PCLK) begin
    if (chk_en) begin
      chk("req_ready", req_ready, e_ready);
      chk("rsp_valid", rsp_valid, e_rsp_valid);
      chk("rsp_rdata", rsp_rdata, e_rdata);
      chk("rsp_error", rsp_error, e_err);
      chk("PSEL1", PSEL1, m_busy && !m_sel2);
      chk("PSEL2", PSEL2, m_busy && m_sel2);
      chk("PENABLE", PENABLE, m_busy && m_t >= 2);
      chk("PWRITE", PWRITE, e_pwrite);
      chk("PADDR", PADDR, e_paddr);
      chk("PWDATA", PWDATA, e_pwdata);
    end
    if (PSEL1 || PSEL2) sel_cyc <= sel_cyc + 1;
    if (PENABLE) pen_cyc <= pen_cyc + 1;
    if (rsp_valid) rsp_cnt <= rsp_cnt + 1;
  end

  task automatic issue(input logic w, input logic [8:0] a,
                       input logic [7:0] d, output logic [7:0] rd,
                       output logic er, output int lat,
                       output int sc, output int pc);
    int n, s0, p0;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge PCLK); n++; end
    if (!req_ready) chk("accept_bound", 32'd0, 32'd1);
    #1 s0 = sel_cyc; p0 = pen_cyc;
    @(negedge PCLK);
    req_valid = 1'b0;
    lat = 1; n = 0;
    while (!rsp_valid && n < 50) begin
      @(negedge PCLK); lat++; n++;
    end
    if (!rsp_valid) chk("rsp_bound", 32'd0, 32'd1);
    rd = rsp_rdata; er = rsp_error;
    #1 sc = sel_cyc - s0; pc = pen_cyc - p0;
  endtask

  logic [7:0] rd;
  logic er;
  int lat, sc, pc;

  initial begin
    int n, k, r0;
    int acc_cyc [3];
    logic [8:0] ba [3];
    logic [7:0] bd [3];
    logic       bw [3];
    ba[0] = 9'h0A0; bd[0] = 8'h11; bw[0] = 1'b1;
    ba[1] = 9'h1A1; bd[1] = 8'h22; bw[1] = 1'b1;
    ba[2] = 9'h0A0; bd[2] = 8'h00; bw[2] = 1'b0;

    @(negedge PCLK);
    chk_en = 1'b1;
    chk("rst_req_ready", req_ready, 0);
    chk("rst_psel2", PSEL2, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    PRESET = 1'b0;

    // slave2 write then read
    issue(1'b1, 9'h13A, 8'hA5, rd, er, lat, sc, pc);
    chk("s2w_lat", lat, 3);
    chk("s2w_sel_cycles", sc, 2);
    chk("s2w_pen_cycles", pc, 1);
    issue(1'b0, 9'h13A, 8'h00, rd, er, lat, sc, pc);
    chk("s2r_lat", lat, 3);
    chk("s2r_data", rd, 8'hA5);
    chk("s2r_err", er, 0);

    // slave1 write then read, slave2 same offset untouched
    issue(1'b1, 9'h005, 8'h3C, rd, er, lat, sc, pc);
    issue(1'b0, 9'h005, 8'h00, rd, er, lat, sc, pc);
    chk("s1r_data", rd, 8'h3C);
    issue(1'b0, 9'h105, 8'h00, rd, er, lat, sc, pc);
    chk("s2_untouched", rd, 8'hC6);

    // three wait states on slave1
    wait1 = 3;
    issue(1'b0, 9'h010, 8'h00, rd, er, lat, sc, pc);
    chk("wait_data", rd, 8'h77);
    chk("wait_err", er, 0);
    chk("wait_pen_cycles", pc, 4);
    chk("wait_lat", lat, 6);
    wait1 = 0;

    // timeout on slave2
    wait2 = 100;
    issue(1'b0, 9'h1F0, 8'h00, rd, er, lat, sc, pc);
    chk("tmo_err", er, 1);
    chk("tmo_data", rd, 8'h00);
    chk("tmo_pen_cycles", pc, 4);
    wait2 = 0;
    issue(1'b0, 9'h1F0, 8'h00, rd, er, lat, sc, pc);
    chk("post_tmo_data", rd, 8'h33);
    chk("post_tmo_err", er, 0);
    chk("post_tmo_lat", lat, 3);

    // reset during ACCESS
    wait1 = 2;
    @(negedge PCLK);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 9'h020;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge PCLK); n++; end
    @(negedge PCLK);
    req_valid = 1'b0;
    @(negedge PCLK);
    chk("mid_in_access", PENABLE, 1);
    PRESET = 1'b1;
    @(negedge PCLK);
    PRESET = 1'b0;
    #1;
    chk("mid_psel1", PSEL1, 0);
    chk("mid_penable", PENABLE, 0);
    chk("mid_paddr", PADDR, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    @(negedge PCLK);
    #1;
    chk("mid_req_ready", req_ready, 1);
    chk("mid_no_rsp", rsp_valid, 0);
    wait1 = 0;

    // back-to-back with req_valid held high
    #1 r0 = rsp_cnt;
    @(negedge PCLK);
    req_valid = 1'b1;
    req_write = bw[0]; req_addr = ba[0]; req_wdata = bd[0];
    k = 0; n = 0;
    while (k < 3 && n < 60) begin
      if (req_ready) begin
        acc_cyc[k] = cyc;
        k++;
        @(negedge PCLK);
        if (k < 3) begin
          req_write = bw[k]; req_addr = ba[k]; req_wdata = bd[k];
        end else begin
          req_valid = 1'b0;
        end
      end else begin
        @(negedge PCLK);
      end
      n++;
    end
    chk("b2b_accepts", k, 3);
    n = 0;
    while (!rsp_valid && n < 20) begin @(negedge PCLK); n++; end
    @(negedge PCLK);
    @(negedge PCLK);
    #1;
    chk("b2b_gap0", acc_cyc[1] - acc_cyc[0], 3);
    chk("b2b_gap1", acc_cyc[2] - acc_cyc[1], 3);
    chk("b2b_rsp_count", rsp_cnt - r0, 3);
    chk("b2b_read_data", rsp_rdata, 8'h11);

    repeat (2) @(negedge PCLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
